// File: rtl/pagerank_sched.sv
// Iterative PageRank scheduler: offers every page to an external rank datapath once per
// iteration, tracks the largest per-page rank delta and stops on convergence or MAX_ITER.
module pagerank_sched #(
  parameter int unsigned       N        = 16,
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       MAX_ITER = 32,
  parameter logic [WIDTH-1:0]  EPS      = 16'h0010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 page_valid,
  input  logic                 page_ready,
  output logic [$clog2(N)-1:0] page_idx,
  input  logic                 res_valid,
  input  logic [WIDTH-1:0]     res_old,
  input  logic [WIDTH-1:0]     res_new,
  output logic                 commit,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [7:0]           iter_count,
  output logic                 err
);

  localparam int unsigned      IdxW     = $clog2(N);
  localparam int unsigned      CntW     = IdxW + 1;
  localparam logic [CntW-1:0]  NCnt     = CntW'(N);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N - 1);
  localparam logic [7:0]       MaxIter8 = 8'(MAX_ITER);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCheck, StFin} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   issue_ptr_q, issue_ptr_d;
  logic [CntW-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [WIDTH-1:0]  max_delta_q, max_delta_d;
  logic [7:0]        iter_q, iter_d;
  logic              conv_q, conv_d;
  logic              err_q, err_d;
  logic              page_valid_q, page_valid_d;
  logic              busy_q, busy_d;
  logic              commit_q, commit_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  abs_delta;
  logic              res_accept;
  logic              issue_fire;

  assign abs_delta  = (res_new >= res_old) ? (res_new - res_old) : (res_old - res_new);
  // Results only count while an iteration is collecting and fewer than N have arrived.
  assign res_accept = res_valid && ((state_q == StIssue) || (state_q == StDrain)) &&
                      (rcv_cnt_q != NCnt);
  assign issue_fire = page_valid_q && page_ready;

  always_comb begin
    state_d     = state_q;
    issue_ptr_d = issue_ptr_q;
    rcv_cnt_d   = rcv_cnt_q;
    max_delta_d = max_delta_q;
    iter_d      = iter_q;
    conv_d      = conv_q;
    err_d       = err_q;

    if (res_valid) begin
      if (res_accept) begin
        rcv_cnt_d = rcv_cnt_q + CntW'(1);
        if (abs_delta > max_delta_q) begin
          max_delta_d = abs_delta;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StIssue;
          issue_ptr_d = '0;
          rcv_cnt_d   = '0;
          max_delta_d = '0;
          iter_d      = '0;
          conv_d      = 1'b0;
        end
      end
      StIssue: begin
        if (issue_fire) begin
          if (issue_ptr_q == LastIdx) begin
            issue_ptr_d = '0;
            // A zero-latency datapath can complete the iteration on the last issue.
            state_d     = (rcv_cnt_d == NCnt) ? StCheck : StDrain;
          end else begin
            issue_ptr_d = issue_ptr_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        if (rcv_cnt_d == NCnt) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        iter_d      = iter_q + 8'd1;
        rcv_cnt_d   = '0;
        max_delta_d = '0;
        if (max_delta_q <= EPS) begin
          conv_d  = 1'b1;
          state_d = StFin;
        end else if (iter_d == MaxIter8) begin
          conv_d  = 1'b0;
          state_d = StFin;
        end else begin
          state_d = StIssue;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    page_valid_d = (state_d == StIssue);
    busy_d       = (state_d != StIdle);
    commit_d     = (state_d == StCheck);
    done_d       = (state_d == StFin);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      issue_ptr_q  <= '0;
      rcv_cnt_q    <= '0;
      max_delta_q  <= '0;
      iter_q       <= '0;
      conv_q       <= 1'b0;
      err_q        <= 1'b0;
      page_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      commit_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_ptr_q  <= issue_ptr_d;
      rcv_cnt_q    <= rcv_cnt_d;
      max_delta_q  <= max_delta_d;
      iter_q       <= iter_d;
      conv_q       <= conv_d;
      err_q        <= err_d;
      page_valid_q <= page_valid_d;
      busy_q       <= busy_d;
      commit_q     <= commit_d;
      done_q       <= done_d;
    end
  end

  assign page_valid = page_valid_q;
  assign page_idx   = issue_ptr_q;
  assign commit     = commit_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign err        = err_q;

endmodule
